// File: rtl/eth_vlg_pkg.sv
// Shared types for the eth_vlg connection manager: address/port types and
// the manager state encoding.
package eth_vlg_pkg;

   typedef logic [31:0] ipv4_t;
   typedef logic [15:0] port_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DHCP    = 3'd1,
      OPEN    = 3'd2,
      UP      = 3'd3,
      HOLDOFF = 3'd4,
      CLOSE   = 3'd5,
      FAIL    = 3'd6
   } conn_mgr_state_t;

   localparam int unsigned BACKOFF_MAX_SHIFT = 4;

endpackage

// File: rtl/eth_vlg_conn_mgr_if.sv
// Control/status bundle between the connection manager (master) and the
// TCP/DHCP core (slave).
interface eth_vlg_conn_mgr_if;
   import eth_vlg_pkg::*;

   logic  dhcp_start;
   logic  connect;
   logic  listen;
   ipv4_t rem_ipv4;
   port_t rem_port;
   port_t loc_port;

   logic  ready;
   logic  dhcp_success;
   logic  dhcp_fail;
   logic  idle;
   logic  listening;
   logic  connecting;
   logic  connected;
   logic  disconnecting;

   modport master (
      output dhcp_start, connect, listen, rem_ipv4, rem_port, loc_port,
      input  ready, dhcp_success, dhcp_fail, idle, listening, connecting,
             connected, disconnecting
   );

   modport slave (
      input  dhcp_start, connect, listen, rem_ipv4, rem_port, loc_port,
      output ready, dhcp_success, dhcp_fail, idle, listening, connecting,
             connected, disconnecting
   );

endinterface

// File: rtl/eth_vlg_conn_mgr.sv
// Connection manager: brings the core up via DHCP, opens/holds one TCP
// connection, retries with holdoff. Define CONN_MGR_BACKOFF_EN for exponential holdoff.
module eth_vlg_conn_mgr
   import eth_vlg_pkg::*;
#(
   parameter int unsigned DHCP_WAIT_TICKS    = 125000000,
   parameter int unsigned CONN_TIMEOUT_TICKS = 125000000,
   parameter int unsigned RETRY_TICKS        = 1250000,
   parameter int unsigned MAX_RETRIES        = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       server,
   input  ipv4_t                      usr_rem_ipv4,
   input  port_t                      usr_rem_port,
   input  port_t                      usr_loc_port,
   eth_vlg_conn_mgr_if.master         core,
   output logic                       link_up,
   output logic                       fail,
   output logic [7:0]                 retries,
   output conn_mgr_state_t            state
);

   localparam logic [31:0] DHCP_LIM = 32'(DHCP_WAIT_TICKS - 1);
   localparam logic [31:0] CONN_LIM = 32'(CONN_TIMEOUT_TICKS - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

   conn_mgr_state_t state_q, state_d;
   logic [31:0]     timer_q, timer_d;
   logic [7:0]      retries_q, retries_d;
   ipv4_t           rem_ipv4_q, rem_ipv4_d;
   port_t           rem_port_q, rem_port_d;
   port_t           loc_port_q, loc_port_d;
   logic            mode_q, mode_d;
   logic            dhcp_start_q, dhcp_start_d;
   logic            connect_q, connect_d;
   logic            listen_q, listen_d;
   logic            link_up_q, link_up_d;
   logic            fail_q, fail_d;
   logic [31:0]     holdoff_lim;
   logic [7:0]      retries_inc;

   logic unused_status;
   assign unused_status = &{1'b0, core.dhcp_success, core.dhcp_fail, core.listening,
                            core.connecting, core.disconnecting};

`ifdef CONN_MGR_BACKOFF_EN
   logic [2:0] backoff_shift;
   always_comb begin
      backoff_shift = '0;
      if (retries_q > 8'(BACKOFF_MAX_SHIFT)) backoff_shift = 3'(BACKOFF_MAX_SHIFT);
      else if (retries_q != '0)              backoff_shift = 3'(retries_q - 8'd1);
      holdoff_lim = (32'(RETRY_TICKS) << backoff_shift) - 32'd1;
   end
`else
   assign holdoff_lim = 32'(RETRY_TICKS - 1);
`endif

   assign retries_inc = (retries_q == '1) ? retries_q : retries_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      retries_d  = retries_q;
      rem_ipv4_d = rem_ipv4_q;
      rem_port_d = rem_port_q;
      loc_port_d = loc_port_q;
      mode_d     = mode_q;

      // en=0 is tested first in every active state so it wins over any other exit
      unique case (state_q)
         IDLE: if (en) begin
            state_d   = DHCP;
            retries_d = '0;
         end
         DHCP: begin
            if (!en)                       state_d = IDLE;
            else if (core.ready)           state_d = OPEN;
            else if (timer_q >= DHCP_LIM)  state_d = FAIL;
         end
         OPEN: begin
            if (!en) state_d = CLOSE;
            else if (core.connected) begin
               state_d   = UP;
               retries_d = '0;
            end else if (!mode_q && timer_q >= CONN_LIM) begin
               state_d   = HOLDOFF;
               retries_d = retries_inc;
            end
         end
         UP: begin
            if (!en) state_d = CLOSE;
            else if (!core.connected) begin
               state_d   = HOLDOFF;
               retries_d = 8'd1;
            end
         end
         HOLDOFF: begin
            if (!en) state_d = CLOSE;
            else if (core.idle && timer_q >= holdoff_lim)
               state_d = (retries_q >= RETRY_MAX) ? FAIL : OPEN;
         end
         CLOSE: if (core.idle) state_d = IDLE;
         FAIL:  if (!en)       state_d = IDLE;
         default:              state_d = IDLE;
      endcase

      if (state_d == OPEN && state_q != OPEN) begin
         rem_ipv4_d = usr_rem_ipv4;
         rem_port_d = usr_rem_port;
         loc_port_d = usr_loc_port;
         mode_d     = server;
      end

      timer_d = (state_d != state_q) ? '0 :
                (timer_q == '1)      ? timer_q : timer_q + 32'd1;

      // Outputs are decoded from the next state so they switch with the state register
      dhcp_start_d = (state_d == DHCP);
      connect_d    = (state_d == OPEN) || (state_d == UP);
      listen_d     = connect_d && mode_d;
      link_up_d    = (state_d == UP);
      fail_d       = (state_d == FAIL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         retries_q    <= '0;
         rem_ipv4_q   <= '0;
         rem_port_q   <= '0;
         loc_port_q   <= '0;
         mode_q       <= 1'b0;
         dhcp_start_q <= 1'b0;
         connect_q    <= 1'b0;
         listen_q     <= 1'b0;
         link_up_q    <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retries_q    <= retries_d;
         rem_ipv4_q   <= rem_ipv4_d;
         rem_port_q   <= rem_port_d;
         loc_port_q   <= loc_port_d;
         mode_q       <= mode_d;
         dhcp_start_q <= dhcp_start_d;
         connect_q    <= connect_d;
         listen_q     <= listen_d;
         link_up_q    <= link_up_d;
         fail_q       <= fail_d;
      end
   end

   assign core.dhcp_start = dhcp_start_q;
   assign core.connect    = connect_q;
   assign core.listen     = listen_q;
   assign core.rem_ipv4   = rem_ipv4_q;
   assign core.rem_port   = rem_port_q;
   assign core.loc_port   = loc_port_q;
   assign link_up         = link_up_q;
   assign fail            = fail_q;
   assign retries         = retries_q;
   assign state           = state_q;

endmodule
